ex_muldiv_unit: RTL and testbench

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/ex_muldiv_unit_if.sv | 23 ++
 rtl/ex_muldiv_unit.sv | 184 ++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// Handshake and operand bus between the EX stage and the iterative RV32M unit.
interface ex_muldiv_unit_if;
   logic        start;
   logic        flush;
   logic [2:0]  op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [4:0]  rd_in;
   logic        stall_req;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   modport master (
      output start, flush, op, src1, src2, rd_in,
      input  stall_req, done, result, rd_out
   );

   modport slave (
      input  start, flush, op, src1, src2, rd_in,
      output stall_req, done, result, rd_out
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 radix-2 iterations on magnitudes,
// one sign-fix cycle, one-cycle done pulse; divide-by-zero/overflow bypass.
module ex_muldiv_unit (
   input logic              clk,
   input logic              rst,
   ex_muldiv_unit_if.slave  bus
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned CW   = 5;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic [4:0]        rd_q, rd_d;
   logic              neg1_q, neg1_d, neg2_q, neg2_d;
   logic [XLEN-1:0]   opa_q, opa_d, opb_q, opb_d;
   logic [2*XLEN-1:0] prod_q, prod_d;
   logic [XLEN-1:0]   quot_q, quot_d, rem_q, rem_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [4:0]        rd_out_q, rd_out_d;
   logic              done_q, done_d;

   logic              s1_signed, s2_signed, s1_neg, s2_neg, is_div, div_zero, div_ovf;
   logic [XLEN-1:0]   abs1, abs2;
   logic [XLEN:0]     msum, dshift, dtrial;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, bypass_quot, bypass_rem;

   // Operand decode for the op presented in IDLE
   always_comb begin
      s1_signed   = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
      s2_signed   = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
      s1_neg      = s1_signed & bus.src1[XLEN-1];
      s2_neg      = s2_signed & bus.src2[XLEN-1];
      abs1        = s1_neg ? (~bus.src1 + 32'd1) : bus.src1;
      abs2        = s2_neg ? (~bus.src2 + 32'd1) : bus.src2;
      is_div      = bus.op[2];
      div_zero    = is_div && (bus.src2 == 32'd0);
      div_ovf     = ((bus.op == 3'd4) || (bus.op == 3'd6)) &&
                    (bus.src1 == 32'h8000_0000) && (bus.src2 == 32'hFFFF_FFFF);
      bypass_quot = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
      bypass_rem  = div_zero ? bus.src1 : 32'd0;
   end

   // One shift-add / restoring shift-subtract step, plus final sign correction
   always_comb begin
      msum     = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opa_q} : 33'd0);
      dshift   = {rem_q, quot_q[XLEN-1]};
      dtrial   = dshift - {1'b0, opb_q};
      prod_fix = (neg1_q ^ neg2_q) ? (~prod_q + 64'd1) : prod_q;
      quot_fix = (neg1_q ^ neg2_q) ? (~quot_q + 32'd1) : quot_q;
      rem_fix  = neg1_q ? (~rem_q + 32'd1) : rem_q;
   end

   // Next-state and datapath control
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      rd_d     = rd_q;
      neg1_d   = neg1_q;
      neg2_d   = neg2_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      prod_d   = prod_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      result_d = result_q;
      rd_out_d = rd_out_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               op_d   = bus.op;
               rd_d   = bus.rd_in;
               neg1_d = s1_neg;
               neg2_d = s2_neg;
               opa_d  = abs1;
               opb_d  = abs2;
               cnt_d  = '0;
               if (div_zero || div_ovf) begin
                  quot_d   = bypass_quot;
                  rem_d    = bypass_rem;
                  result_d = bus.op[1] ? bypass_rem : bypass_quot;
                  rd_out_d = bus.rd_in;
                  done_d   = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  prod_d  = {32'd0, abs2};
                  quot_d  = abs1;
                  rem_d   = '0;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (op_q[2]) begin
               if (!dtrial[XLEN]) begin
                  rem_d  = dtrial[XLEN-1:0];
                  quot_d = {quot_q[XLEN-2:0], 1'b1};
               end else begin
                  rem_d  = dshift[XLEN-1:0];
                  quot_d = {quot_q[XLEN-2:0], 1'b0};
               end
            end else begin
               prod_d = {msum, prod_q[XLEN-1:1]};
            end
            cnt_d = CW'(cnt_q + 5'd1);
            if (cnt_q == 5'd31) state_d = S_FIX;
         end
         S_FIX: begin
            prod_d   = prod_fix;
            quot_d   = quot_fix;
            rem_d    = rem_fix;
            case (op_q)
               3'd0:          result_d = prod_fix[XLEN-1:0];
               3'd1, 3'd2,
               3'd3:          result_d = prod_fix[2*XLEN-1:XLEN];
               3'd4, 3'd5:    result_d = quot_fix;
               default:       result_d = rem_fix;
            endcase
            rd_out_d = rd_q;
            done_d   = 1'b1;
            state_d  = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      // A killed op must not publish anything
      if (bus.flush) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         done_d   = 1'b0;
         result_d = result_q;
         rd_out_d = rd_out_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         rd_q     <= '0;
         neg1_q   <= 1'b0;
         neg2_q   <= 1'b0;
         opa_q    <= '0;
         opb_q    <= '0;
         prod_q   <= '0;
         quot_q   <= '0;
         rem_q    <= '0;
         result_q <= '0;
         rd_out_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         neg1_q   <= neg1_d;
         neg2_q   <= neg2_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         prod_q   <= prod_d;
         quot_q   <= quot_d;
         rem_q    <= rem_d;
         result_q <= result_d;
         rd_out_q <= rd_out_d;
         done_q   <= done_d;
      end
   end

   assign bus.stall_req = ~rst & (((state_q == S_IDLE) & bus.start) |
                                  (state_q == S_CALC) | (state_q == S_FIX));
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.rd_out    = rd_out_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vector table, corner-case
// sequences (flush, reset, busy start) and random ops against an arithmetic model.
module tb_ex_muldiv_unit;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   ex_muldiv_unit_if bus ();

   ex_muldiv_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t tv[16];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // RV32M semantics from plain wide arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      logic            ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = 64'(a);
      ub  = 64'(b);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (o)
         3'd0: begin p = ua * ub;               return p[31:0];  end
         3'd1: begin p = 64'(sa * sb);          return p[63:32]; end
         3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
         3'd3: begin p = ua * ub;               return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) return a;
            if (ovf) return 32'd0;
            return 32'(sa % sb);
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      if (o[2] && b == 32'd0) return 1;
      if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
      @(negedge clk);
      bus.start = 1'b1;
      bus.flush = 1'b0;
      bus.op    = o;
      bus.src1  = a;
      bus.src2  = b;
      bus.rd_in = rd;
      #1 chk("stall_on_start", 64'(bus.stall_req), 64'd1);
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // Counts edges from the latching edge until done is seen (bounded)
   task automatic wait_done(input int e0, output int edges, output bit stall_ok);
      edges    = e0;
      stall_ok = 1'b1;
      while (edges < 100) begin
         @(negedge clk);
         if (bus.done) break;
         if (!bus.stall_req) stall_ok = 1'b0;
         @(posedge clk);
         edges++;
      end
   endtask

   task automatic finish_op(input string tag, input int edges, input bit stall_ok,
                            input logic [31:0] exp, input logic [4:0] exp_rd, input int exp_lat);
      logic [31:0] held;
      chk({tag, "_latency"}, 64'(edges), 64'(exp_lat));
      chk({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
      chk({tag, "_result"}, 64'(bus.result), 64'(exp));
      chk({tag, "_rd_out"}, 64'(bus.rd_out), 64'(exp_rd));
      chk({tag, "_stall_in_done"}, 64'(bus.stall_req), 64'd0);
      held = bus.result;
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
      chk({tag, "_result_hold"}, 64'(bus.result), 64'(held));
   endtask

   task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
      int edges;
      bit sok;
      launch(o, a, b, rd);
      wait_done(1, edges, sok);
      finish_op(tag, edges, sok, exp, rd, exp_lat);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          edges;
      bit          sok;
      bit          seen;
      logic [31:0] prev;
      logic [2:0]  o;
      logic [31:0] a, b;
      logic [4:0]  rd;

      checks = 0;
      errors = 0;

      tv[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 34};
      tv[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 34};
      tv[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'h0000_0000, 34};
      tv[3]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 34};
      tv[4]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd5,  32'hFFFF_FFFF, 34};
      tv[5]  = '{3'd5, 32'h0000_1234,  32'd0,         5'd6,  32'hFFFF_FFFF, 1};
      tv[6]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 1};
      tv[7]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 1};
      tv[8]  = '{3'd7, 32'h0000_1234,  32'd0,         5'd9,  32'h0000_1234, 1};
      tv[9]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         5'd10, 32'hFFFF_FFFF, 34};
      tv[10] = '{3'd5, 32'd100,        32'd7,         5'd11, 32'd14,        34};
      tv[11] = '{3'd7, 32'd100,        32'd7,         5'd12, 32'd2,         34};
      tv[12] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 5'd13, 32'd1,         34};
      tv[13] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, 34};
      tv[14] = '{3'd0, 32'h0001_0000,  32'h0001_0000, 5'd15, 32'd0,         34};
      tv[15] = '{3'd3, 32'h0001_0000,  32'h0001_0000, 5'd31, 32'd1,         34};

      // Reset state, with start already high
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.flush = 1'b0;
      bus.op    = 3'd0;
      bus.src1  = 32'd3;
      bus.src2  = 32'd4;
      bus.rd_in = 5'd1;
      repeat (2) @(negedge clk);
      chk("rst_stall", 64'(bus.stall_req), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_result", 64'(bus.result), 64'd0);
      chk("rst_rd_out", 64'(bus.rd_out), 64'd0);
      rst       = 1'b0;
      bus.start = 1'b0;

      for (int i = 0; i < 16; i++)
         do_op($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, tv[i].rd, tv[i].exp, tv[i].lat);

      // Flush at count 10, then a new op in the very next cycle
      launch(3'd4, 32'd1000, 32'd7, 5'd20);
      repeat (10) @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      prev = bus.result;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      chk("flush_done", 64'(bus.done), 64'd0);
      chk("flush_result_kept", 64'(bus.result), 64'(prev));
      do_op("after_flush", 3'd0, 32'd12, 32'd11, 5'd21, 32'd132, 34);

      // Flush wins over a simultaneous start
      @(negedge clk);
      bus.start = 1'b1;
      bus.flush = 1'b1;
      bus.op    = 3'd0;
      bus.src1  = 32'd2;
      bus.src2  = 32'd2;
      @(posedge clk);
      #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done || bus.stall_req) seen = 1'b1;
      end
      chk("flush_beats_start", 64'(seen), 64'd0);

      // Reset in the middle of CALC
      launch(3'd0, 32'd9, 32'd9, 5'd22);
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      bus.start = 1'b1;
      #1;
      chk("midrst_done", 64'(bus.done), 64'd0);
      chk("midrst_result", 64'(bus.result), 64'd0);
      chk("midrst_rd_out", 64'(bus.rd_out), 64'd0);
      chk("midrst_stall", 64'(bus.stall_req), 64'd0);
      @(negedge clk);
      rst       = 1'b0;
      bus.start = 1'b0;
      do_op("after_rst", 3'd5, 32'd50, 32'd5, 5'd23, 32'd10, 34);

      // start while busy is ignored
      launch(3'd5, 32'd1000, 32'd3, 5'd9);
      repeat (10) begin
         bus.start = 1'b1;
         bus.op    = 3'd0;
         bus.src1  = 32'd5;
         bus.src2  = 32'd5;
         bus.rd_in = 5'd3;
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      wait_done(11, edges, sok);
      finish_op("busy_start", edges, sok, 32'd333, 5'd9, 34);

      // Random ops against the model
      for (int i = 0; i < 150; i++) begin
         o  = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         rd = 5'($urandom_range(0, 31));
         do_op($sformatf("rnd%0d_op%0d_%h_%h", i, o, a, b), o, a, b, rd,
               ref_model(o, a, b), ref_lat(o, a, b));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
